shared_net_arbiter: RTL
=======================

# shared_net_arbiter

Round-robin arbiter that shares one multi-driver net group (e.g. the z/y/x inout nets tied across sibling instances in `top`) between up to `N_REQ` driving submodules. It grants ownership to exactly one requester at a time and gates that requester's output enable. Between owners it enforces a turnaround gap with no driver enabled, so the shared nets never see contention. Preemption after a bounded hold time keeps any requester from starving the others. The block instantiates once per shared net group, beside the instances it arbitrates.

## Interface
- `N_REQ`, 4: number of requesters, 2..8
- `MAX_HOLD`, 16: maximum contiguous grant cycles while another requester waits, ≥2
- `TURN_CYC`, 1: turnaround cycles with all drivers disabled between owners, ≥1

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous reset, active-high
- `req` in N_REQ: level request per requester; held high while the requester wants the net
- `gnt` out N_REQ: one-hot grant, registered
- `drv_en` out N_REQ: one-hot driver enable, equal to `gnt` in GRANT state, otherwise 0
- `keep_en` out 1: high when `drv_en` is all-zero; enables the net keeper / default tie-off
- `owner` out clog2(N_REQ): index of current/last owner
- `busy` out 1: high in GRANT or TURN
- `preempt` out 1: one-cycle pulse when a grant is forcibly ended by the hold limit

## Operation
- Reset values:
  - `gnt`=0, `drv_en`=0, `keep_en`=1, `owner`=0, `busy`=0, `preempt`=0.
  - Priority pointer = 0; hold counter = 0; state IDLE.
- States:
  - IDLE: no owner. If `req`≠0, pick the first set bit searching from the pointer upward with wrap. Load `gnt`/`drv_en`/`owner`, clear the hold counter, go to GRANT.
  - GRANT: `drv_en`=`gnt`. The hold counter increments each cycle and saturates at `MAX_HOLD`.
    - `req[owner]`=0 → release.
    - Hold counter = `MAX_HOLD`−1 and another `req` bit set → release with `preempt`=1.
    - Hold counter at limit with no other request → keep the grant indefinitely.
    - On release: `gnt`, `drv_en` ← 0; pointer ← owner+1 mod `N_REQ`; turnaround counter ← `TURN_CYC`; go to TURN.
  - TURN: all enables 0, `busy`=1, counter decrements each cycle. On the cycle the counter reaches 1:
    - If `req`≠0, arbitrate exactly as in IDLE and go directly to GRANT.
    - Otherwise go to IDLE.
- `owner` holds its last value through TURN and IDLE.
- The pointer advances only on release, so the owner just released has lowest priority.
- `req` changes during TURN are sampled only at the arbitration cycle.
- A `req` bit dropping before it is granted is never granted.
- Counter widths:
  - Hold counter: clog2(`MAX_HOLD`+1) bits.
  - Turnaround counter: clog2(`TURN_CYC`+1) bits.
  - Pointer: clog2(`N_REQ`) bits, with explicit wrap at `N_REQ` (non-power-of-2 `N_REQ` is legal).
- Invariant: `$onehot0(drv_en)` holds in every cycle, and `drv_en` is never nonzero in two consecutive cycles with different values.

## Timing
- Grant latency from IDLE: `req` high at edge t gives `gnt`/`drv_en` high after edge t+1, i.e. a 1-cycle latency.
- Release latency: `req[owner]` low at edge t gives `gnt`/`drv_en` low after edge t+1.
- Handover gap: owner A's `drv_en` falls, then owner B's `drv_en` rises exactly `TURN_CYC` cycles later. B's first enabled cycle is `TURN_CYC`+1 cycles after A's last enabled cycle.
- Preemption: the owner holds `drv_en` for exactly `MAX_HOLD` cycles when contested. `preempt` is high in the first TURN cycle only.
- `rst` asserted at any time clears all outputs immediately, without waiting for a clock edge. On the first edge after `rst` falls, the block is in IDLE and can grant.

## Test plan
- Reset mid-grant (`req`=4'b0010, granted, `rst` pulsed between edges) → `gnt`=0, `drv_en`=0, `keep_en`=1 immediately. After release, `req` still 4'b0010 → `gnt`=4'b0010 one cycle later.
- Single request: `req`=4'b0100 at cycle 0 → `gnt`=`drv_en`=4'b0100 and `owner`=2 from cycle 1. `req` dropped at cycle 5 → `gnt`=0 at cycle 6, `busy`=1 for 1 cycle, then IDLE with `keep_en`=1.
- All request, `TURN_CYC`=1: `req`=4'b1111, each owner drops its `req` 3 cycles after its grant → grant order 0,1,2,3. Between owners, exactly one `drv_en`=0 cycle; never two `drv_en` bits set.
- Preemption, `MAX_HOLD`=16: `req[0]` held, `req[1]` raised 2 cycles after grant 0 → `drv_en[0]` high for exactly 16 cycles, `preempt` pulses once, `drv_en[1]` rises one cycle later.
- Uncontested hold: `req`=4'b0001 alone for 40 cycles → `gnt` stays 4'b0001 throughout, `preempt` never set.
- Fairness: owner 3 releases and re-requests immediately while `req[0]` is high → pointer wrap grants 0 before 3 again. `N_REQ`=3 variant wraps from 2 to 0.

Source files
------------

// File: rtl/shared_net_arbiter_if.sv
// Bundle of the request/grant signals between a shared net group's drivers
// and the arbiter that owns that group.
//
// Handshake: req[i] is a level request. The requester raises it and keeps it
// high for as long as it wants the net. gnt[i]/drv_en[i] answer it, one
// requester at a time. The owner gives the net back by lowering req[i].
// There is no valid/ready pairing. A request that drops before it is granted
// simply disappears.
interface shared_net_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] drv_en;
   logic             keep_en;
   logic [OW-1:0]    owner;
   logic             busy;
   logic             preempt;
   logic [1:0]       state;    // debug view of the arbiter FSM

   modport master (
      output req,
      input  gnt, drv_en, keep_en, owner, busy, preempt, state
   );

   modport slave (
      input  req,
      output gnt, drv_en, keep_en, owner, busy, preempt, state
   );
endinterface

// File: rtl/shared_net_arbiter.sv
// shared_net_arbiter: grants one shared multi-driver net group to one
// requester at a time. Owners are picked round-robin. Every change of owner
// is separated by a gap of TURN_CYC cycles with no driver enabled. A
// contested owner is preempted after MAX_HOLD cycles.
module shared_net_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 16,
   parameter int TURN_CYC = 1
) (
   input logic                 clk,
   input logic                 rst,
   shared_net_arbiter_if.slave bus
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam int TW = $clog2(TURN_CYC + 1);

   localparam logic [HW-1:0]    HOLD_MAX  = HW'(MAX_HOLD);
   localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [TW-1:0]    TURN_LOAD = TW'(TURN_CYC);
   localparam logic [TW-1:0]    TURN_ONE  = TW'(1);
   localparam logic [PW-1:0]    LAST_IDX  = PW'(N_REQ - 1);
   localparam logic [N_REQ-1:0] GNT_ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   state_t state;
   state_t state_n;

   logic [N_REQ-1:0] gnt_q;
   logic [PW-1:0]    owner_q;
   logic [PW-1:0]    ptr_q;
   logic [HW-1:0]    hold_q;
   logic [TW-1:0]    turn_q;
   logic             preempt_q;

   logic             pick_valid;
   logic [PW-1:0]    pick_idx;
   logic [PW-1:0]    ptr_next;
   logic             owner_req;
   logic             others_req;
   logic             hold_expired;
   logic             turn_done;
   logic             rel_drop;
   logic             rel_preempt;
   logic             release_now;
   logic             grant_load;
   logic [N_REQ-1:0] drv_en_c;

   // Round-robin pick: first set request at or above the pointer, wrapping
   // back through index 0. The pointer range is not a power of two in general,
   // so the wrap is an explicit subtraction.
   always_comb begin
      int idx;
      logic [PW-1:0] cand;
      pick_valid = 1'b0;
      pick_idx   = ptr_q;
      idx        = 0;
      cand       = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         cand = PW'(idx);
         if (!pick_valid && bus.req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Release conditions and the owner that follows a release.
   always_comb begin
      owner_req  = bus.req[owner_q];
      others_req = |(bus.req & ~gnt_q);
      // The counter only parks at MAX_HOLD when nobody else is waiting. A
      // request that shows up later must still be able to end the grant, so
      // the limit is compared with >= and not with ==.
      hold_expired = (hold_q >= HOLD_LAST);
      turn_done    = (turn_q == TURN_ONE);
      rel_drop     = (state == ST_GRANT) && !owner_req;
      rel_preempt  = (state == ST_GRANT) && owner_req && hold_expired && others_req;
      release_now  = rel_drop || rel_preempt;
      ptr_next     = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // FSM next-state logic. Arbitration happens only in IDLE and in the last
   // TURN cycle, so a req change earlier in TURN is never seen.
   always_comb begin
      state_n    = state;
      grant_load = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_n    = ST_GRANT;
               grant_load = 1'b1;
            end
         end
         ST_GRANT: begin
            if (release_now) begin
               state_n = ST_TURN;
            end
         end
         ST_TURN: begin
            if (turn_done) begin
               if (pick_valid) begin
                  state_n    = ST_GRANT;
                  grant_load = 1'b1;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Grant, owner, pointer, hold and turnaround registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q     <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         turn_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= 1'b0;
         if (grant_load) begin
            gnt_q   <= GNT_ONE << pick_idx;
            owner_q <= pick_idx;
            hold_q  <= '0;
         end else if (release_now) begin
            // The owner that is just leaving gets the lowest priority next time.
            gnt_q     <= '0;
            ptr_q     <= ptr_next;
            turn_q    <= TURN_LOAD;
            preempt_q <= rel_preempt;
         end else if ((state == ST_GRANT) && (hold_q != HOLD_MAX)) begin
            hold_q <= hold_q + HW'(1);
         end
         if (state == ST_TURN) begin
            turn_q <= turn_q - TW'(1);
         end
      end
   end

   // FSM outputs. A driver is enabled only in GRANT, so the keeper holds the
   // nets whenever the FSM is in TURN or IDLE.
   always_comb begin
      drv_en_c = '0;
      if (state == ST_GRANT) begin
         drv_en_c = gnt_q;
      end
      bus.gnt     = gnt_q;
      bus.drv_en  = drv_en_c;
      bus.keep_en = ~|drv_en_c;
      bus.owner   = owner_q;
      bus.busy    = (state != ST_IDLE);
      bus.preempt = preempt_q;
      bus.state   = state;
   end

endmodule
